// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the unified-memory arbiter into one interface.
//   - Fetch side (IF):  ifReq/ifAddr/ifFlush in, ifRdata/ifDone/ifStall out.
//   - Data side (MEM):  dmReq/dmWe/dmAddr/dmWdata in, dmRdata/dmDone/dmStall out.
//   - Memory side:      memReq/memWe/memAddr/memWdata out, memRdata/memReady in.
//   modport slave  : the arbiter's view (requests and memory responses come in).
//   modport master : the surrounding pipeline plus memory (drives requests and responses).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // Instruction-fetch requester
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifFlush;
    logic [DATA_W-1:0] ifRdata;
    logic              ifDone;
    logic              ifStall;

    // Data-memory requester
    logic              dmReq;
    logic              dmWe;
    logic [ADDR_W-1:0] dmAddr;
    logic [DATA_W-1:0] dmWdata;
    logic [DATA_W-1:0] dmRdata;
    logic              dmDone;
    logic              dmStall;

    // Unified memory port
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memReady;

    modport slave (
        input  ifReq, ifAddr, ifFlush,
        output ifRdata, ifDone, ifStall,
        input  dmReq, dmWe, dmAddr, dmWdata,
        output dmRdata, dmDone, dmStall,
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memReady
    );

    modport master (
        output ifReq, ifAddr, ifFlush,
        input  ifRdata, ifDone, ifStall,
        output dmReq, dmWe, dmAddr, dmWdata,
        input  dmRdata, dmDone, dmStall,
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memReady
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between instruction fetch
//   and the data-memory stage. One transaction is outstanding at a time; the
//   data side wins when both ask in the same cycle. Read data is returned in
//   registers together with a one-cycle Done pulse, and the stall outputs hold
//   the requesting pipeline stage until its access completes. A flush from ID
//   while a fetch is in flight makes the arbiter drop that fetch's result.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch, data and memory sides)
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_r;
    logic              discard_r;   // in-flight fetch was flushed; drop its data
    logic              memReq_r;
    logic              memWe_r;
    logic [ADDR_W-1:0] memAddr_r;
    logic [DATA_W-1:0] memWdata_r;
    logic [DATA_W-1:0] ifRdata_r;
    logic [DATA_W-1:0] dmRdata_r;
    logic              ifDone_r;
    logic              dmDone_r;

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            discard_r  <= 1'b0;
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= {ADDR_W{1'b0}};
            memWdata_r <= {DATA_W{1'b0}};
            ifRdata_r  <= {DATA_W{1'b0}};
            dmRdata_r  <= {DATA_W{1'b0}};
            ifDone_r   <= 1'b0;
            dmDone_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.dmReq) begin
                        // The data access belongs to the older instruction.
                        memReq_r   <= 1'b1;
                        memWe_r    <= bus.dmWe;
                        memAddr_r  <= bus.dmAddr;
                        memWdata_r <= bus.dmWdata;
                        state_r    <= BUSY_MEM;
                    end else if (bus.ifReq) begin
                        memReq_r  <= 1'b1;
                        memWe_r   <= 1'b0;
                        memAddr_r <= bus.ifAddr;
                        discard_r <= 1'b0;
                        state_r   <= BUSY_IF;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                BUSY_IF: begin
                    if (bus.memReady) begin
                        memReq_r  <= 1'b0;
                        discard_r <= 1'b0;
                        // A flush arriving together with memReady still kills the fetch.
                        if (discard_r || bus.ifFlush) begin
                            state_r <= IDLE;
                        end else begin
                            ifRdata_r <= bus.memRdata;
                            ifDone_r  <= 1'b1;
                            state_r   <= DONE;
                        end
                    end else begin
                        discard_r <= discard_r | bus.ifFlush;
                        state_r   <= BUSY_IF;
                    end
                end

                BUSY_MEM: begin
                    if (bus.memReady) begin
                        memReq_r <= 1'b0;
                        // Stores leave the load-data register untouched.
                        if (!memWe_r) begin
                            dmRdata_r <= bus.memRdata;
                        end else begin
                            dmRdata_r <= dmRdata_r;
                        end
                        dmDone_r <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        state_r <= BUSY_MEM;
                    end
                end

                DONE: begin
                    // Requester's req is still high for the finished item here,
                    // so no grant is made; arbitration resumes from IDLE.
                    ifDone_r <= 1'b0;
                    dmDone_r <= 1'b0;
                    state_r  <= IDLE;
                end

                default: begin
                    memReq_r  <= 1'b0;
                    ifDone_r  <= 1'b0;
                    dmDone_r  <= 1'b0;
                    discard_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.memReq   = memReq_r;
    assign bus.memWe    = memWe_r;
    assign bus.memAddr  = memAddr_r;
    assign bus.memWdata = memWdata_r;
    assign bus.ifRdata  = ifRdata_r;
    assign bus.dmRdata  = dmRdata_r;
    assign bus.ifDone   = ifDone_r;
    assign bus.dmDone   = dmDone_r;

    // Stalls are combinational so the pipeline holds in the same cycle it asks.
    assign bus.ifStall  = bus.ifReq & ~ifDone_r;
    assign bus.dmStall  = bus.dmReq & ~dmDone_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A cycle-by-cycle vector table covers
//   zero-wait fetch, back-to-back loads, a store with wait states and a stray
//   memReady; hand-written sequences cover contention, flush and reset.
//   Inputs for a cycle are driven on the falling edge and outputs checked 1
//   time unit later, before the rising edge that ends the cycle.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    typedef struct {
        // inputs for the cycle
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic        memReady;
        logic [31:0] memRdata;
        // outputs expected during the cycle
        logic        eMemReq;
        logic        eMemWe;
        logic [31:0] eMemAddr;
        logic [31:0] eMemWdata;
        logic        eIfDone;
        logic [31:0] eIfRdata;
        logic        eDmDone;
        logic [31:0] eDmRdata;
        logic        eIfStall;
        logic        eDmStall;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addVec(
        input logic ifReq, input logic [31:0] ifAddr,
        input logic dmReq, input logic dmWe, input logic [31:0] dmAddr, input logic [31:0] dmWdata,
        input logic memReady, input logic [31:0] memRdata,
        input logic eMemReq, input logic eMemWe, input logic [31:0] eMemAddr, input logic [31:0] eMemWdata,
        input logic eIfDone, input logic [31:0] eIfRdata, input logic eDmDone, input logic [31:0] eDmRdata,
        input logic eIfStall, input logic eDmStall);
        vec_t v;
        v.ifReq = ifReq;       v.ifAddr = ifAddr;
        v.dmReq = dmReq;       v.dmWe = dmWe;         v.dmAddr = dmAddr;     v.dmWdata = dmWdata;
        v.memReady = memReady; v.memRdata = memRdata;
        v.eMemReq = eMemReq;   v.eMemWe = eMemWe;     v.eMemAddr = eMemAddr; v.eMemWdata = eMemWdata;
        v.eIfDone = eIfDone;   v.eIfRdata = eIfRdata; v.eDmDone = eDmDone;   v.eDmRdata = eDmRdata;
        v.eIfStall = eIfStall; v.eDmStall = eDmStall;
        vecs.push_back(v);
    endtask

    initial begin
        rst          = 1'b1;
        bus.ifReq    = 1'b0;
        bus.ifAddr   = 32'h0;
        bus.ifFlush  = 1'b0;
        bus.dmReq    = 1'b0;
        bus.dmWe     = 1'b0;
        bus.dmAddr   = 32'h0;
        bus.dmWdata  = 32'h0;
        bus.memReady = 1'b0;
        bus.memRdata = 32'h0;

        //      ifR ifAddr  dmR we dmAddr  dmWdata       rdy memRdata      | mReq mWe memAddr  memWdata      ifD ifRdata       dmD dmRdata       ifS dmS
        // zero-wait fetch of 0x40
        addVec(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        addVec(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0);
        addVec(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b1, 32'h8C220004, 1'b1, 1'b0, 32'h040, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0);
        addVec(1'b1, 32'h40, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h040, 32'h00000000, 1'b1, 32'h8C220004, 1'b0, 32'h00000000, 1'b0, 1'b0);
        addVec(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h040, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h00000000, 1'b0, 1'b0);
        // back-to-back zero-wait loads 0x10, 0x14
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h040, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h00000000, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h010, 32'h00000000, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h00000000, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h8C220004, 1'b1, 32'h11111111, 1'b0, 1'b0);
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h11111111, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h014, 32'h00000000, 1'b1, 32'h22222222, 1'b1, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h11111111, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h8C220004, 1'b1, 32'h22222222, 1'b0, 1'b0);
        addVec(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b0);
        // store 0xDEADBEEF to 0x200 with one wait state; dmRdata must not move
        addVec(1'b0, 32'h00, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h014, 32'h00000000, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b1);
        addVec(1'b0, 32'h00, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h8C220004, 1'b1, 32'h22222222, 1'b0, 1'b0);
        // stray memReady while idle is ignored
        addVec(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b1, 32'h55555555, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b0);
        addVec(1'b0, 32'h00, 1'b0, 1'b0, 32'h000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h8C220004, 1'b0, 32'h22222222, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.ifReq    = vecs[i].ifReq;
            bus.ifAddr   = vecs[i].ifAddr;
            bus.dmReq    = vecs[i].dmReq;
            bus.dmWe     = vecs[i].dmWe;
            bus.dmAddr   = vecs[i].dmAddr;
            bus.dmWdata  = vecs[i].dmWdata;
            bus.memReady = vecs[i].memReady;
            bus.memRdata = vecs[i].memRdata;
            #1;
            chk1 ($sformatf("row%0d.memReq",   i), bus.memReq,   vecs[i].eMemReq);
            chk1 ($sformatf("row%0d.memWe",    i), bus.memWe,    vecs[i].eMemWe);
            chk32($sformatf("row%0d.memAddr",  i), bus.memAddr,  vecs[i].eMemAddr);
            chk32($sformatf("row%0d.memWdata", i), bus.memWdata, vecs[i].eMemWdata);
            chk1 ($sformatf("row%0d.ifDone",   i), bus.ifDone,   vecs[i].eIfDone);
            chk32($sformatf("row%0d.ifRdata",  i), bus.ifRdata,  vecs[i].eIfRdata);
            chk1 ($sformatf("row%0d.dmDone",   i), bus.dmDone,   vecs[i].eDmDone);
            chk32($sformatf("row%0d.dmRdata",  i), bus.dmRdata,  vecs[i].eDmRdata);
            chk1 ($sformatf("row%0d.ifStall",  i), bus.ifStall,  vecs[i].eIfStall);
            chk1 ($sformatf("row%0d.dmStall",  i), bus.dmStall,  vecs[i].eDmStall);
            @(negedge clk);
        end

        // Contention: fetch 0x44 and load 0x100 rise together; load served first
        // (memReady on its 2nd wait cycle), then the fetch (memReady on 2nd memReq cycle).
        bus.ifReq = 1'b1; bus.ifAddr = 32'h44;
        bus.dmReq = 1'b1; bus.dmWe = 1'b0; bus.dmAddr = 32'h100; bus.dmWdata = 32'h0;
        bus.memReady = 1'b0;
        #1;
        chk1("cont.t0.memReq", bus.memReq, 1'b0);
        chk1("cont.t0.ifStall", bus.ifStall, 1'b1);
        chk1("cont.t0.dmStall", bus.dmStall, 1'b1);
        @(negedge clk); #1;
        chk1 ("cont.t1.memReq", bus.memReq, 1'b1);
        chk32("cont.t1.memAddr", bus.memAddr, 32'h100);
        chk1 ("cont.t1.memWe", bus.memWe, 1'b0);
        @(negedge clk); #1;
        chk1("cont.t2.memReq", bus.memReq, 1'b1);
        @(negedge clk);
        bus.memReady = 1'b1; bus.memRdata = 32'h33333333;
        #1;
        chk1("cont.t3.dmDone", bus.dmDone, 1'b0);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk1 ("cont.t4.dmDone", bus.dmDone, 1'b1);
        chk32("cont.t4.dmRdata", bus.dmRdata, 32'h33333333);
        chk1 ("cont.t4.ifDone", bus.ifDone, 1'b0);
        chk1 ("cont.t4.ifStall", bus.ifStall, 1'b1);
        chk1 ("cont.t4.dmStall", bus.dmStall, 1'b0);
        @(negedge clk);
        bus.dmReq = 1'b0;
        #1;
        chk1("cont.t5.memReq", bus.memReq, 1'b0);
        chk1("cont.t5.dmDone", bus.dmDone, 1'b0);
        chk1("cont.t5.ifStall", bus.ifStall, 1'b1);
        @(negedge clk); #1;
        chk1 ("cont.t6.memReq", bus.memReq, 1'b1);
        chk32("cont.t6.memAddr", bus.memAddr, 32'h44);
        chk1 ("cont.t6.memWe", bus.memWe, 1'b0);
        chk1 ("cont.t6.ifStall", bus.ifStall, 1'b1);
        @(negedge clk);
        bus.memReady = 1'b1; bus.memRdata = 32'h44444444;
        #1;
        chk1("cont.t7.ifDone", bus.ifDone, 1'b0);
        chk1("cont.t7.ifStall", bus.ifStall, 1'b1);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk1 ("cont.t8.ifDone", bus.ifDone, 1'b1);
        chk32("cont.t8.ifRdata", bus.ifRdata, 32'h44444444);
        chk1 ("cont.t8.ifStall", bus.ifStall, 1'b0);
        @(negedge clk);
        bus.ifReq = 1'b0;
        #1;
        chk1("cont.t9.ifDone", bus.ifDone, 1'b0);
        @(negedge clk);

        // Flush in the second BUSY_IF cycle, memReady one cycle later.
        bus.ifReq = 1'b1; bus.ifAddr = 32'h60;
        #1;
        @(negedge clk); #1;
        chk1 ("flush.t1.memReq", bus.memReq, 1'b1);
        chk32("flush.t1.memAddr", bus.memAddr, 32'h60);
        @(negedge clk);
        bus.ifFlush = 1'b1;
        #1;
        @(negedge clk);
        bus.ifFlush = 1'b0; bus.ifReq = 1'b0;
        bus.memReady = 1'b1; bus.memRdata = 32'h66666666;
        #1;
        chk1("flush.t3.memReq", bus.memReq, 1'b1);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk1 ("flush.t4.ifDone", bus.ifDone, 1'b0);
        chk32("flush.t4.ifRdata", bus.ifRdata, 32'h44444444);
        chk1 ("flush.t4.memReq", bus.memReq, 1'b0);
        @(negedge clk);
        bus.ifReq = 1'b1; bus.ifAddr = 32'h80;
        #1;
        chk1("flush.t5.ifDone", bus.ifDone, 1'b0);
        chk1("flush.t5.memReq", bus.memReq, 1'b0);
        @(negedge clk);
        bus.memReady = 1'b1; bus.memRdata = 32'h88888888;
        #1;
        chk1 ("flush.t6.memReq", bus.memReq, 1'b1);
        chk32("flush.t6.memAddr", bus.memAddr, 32'h80);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk1 ("flush.t7.ifDone", bus.ifDone, 1'b1);
        chk32("flush.t7.ifRdata", bus.ifRdata, 32'h88888888);
        @(negedge clk);
        bus.ifReq = 1'b0;
        #1;
        chk1("flush.t8.ifDone", bus.ifDone, 1'b0);
        @(negedge clk);

        // Flush arriving in the same cycle as memReady.
        bus.ifReq = 1'b1; bus.ifAddr = 32'h90;
        #1;
        @(negedge clk);
        bus.ifFlush = 1'b1; bus.memReady = 1'b1; bus.memRdata = 32'h99999999;
        #1;
        chk1("flrdy.t1.memReq", bus.memReq, 1'b1);
        @(negedge clk);
        bus.ifFlush = 1'b0; bus.memReady = 1'b0; bus.ifReq = 1'b0;
        #1;
        chk1 ("flrdy.t2.ifDone", bus.ifDone, 1'b0);
        chk32("flrdy.t2.ifRdata", bus.ifRdata, 32'h88888888);
        chk1 ("flrdy.t2.memReq", bus.memReq, 1'b0);
        @(negedge clk); #1;
        chk1("flrdy.t3.ifDone", bus.ifDone, 1'b0);
        @(negedge clk);

        // Reset while a store is waiting on memory.
        bus.dmReq = 1'b1; bus.dmWe = 1'b1; bus.dmAddr = 32'h300; bus.dmWdata = 32'hCAFEF00D;
        #1;
        @(negedge clk); #1;
        chk1 ("rst.t1.memReq", bus.memReq, 1'b1);
        chk1 ("rst.t1.memWe", bus.memWe, 1'b1);
        chk32("rst.t1.memWdata", bus.memWdata, 32'hCAFEF00D);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dmReq = 1'b0; bus.dmWe = 1'b0;
        bus.memReady = 1'b1; bus.memRdata = 32'h77777777;
        #1;
        chk1 ("rst.t2.memReq", bus.memReq, 1'b0);
        chk1 ("rst.t2.memWe", bus.memWe, 1'b0);
        chk32("rst.t2.memAddr", bus.memAddr, 32'h0);
        chk32("rst.t2.memWdata", bus.memWdata, 32'h0);
        chk32("rst.t2.ifRdata", bus.ifRdata, 32'h0);
        chk32("rst.t2.dmRdata", bus.dmRdata, 32'h0);
        chk1 ("rst.t2.ifDone", bus.ifDone, 1'b0);
        chk1 ("rst.t2.dmDone", bus.dmDone, 1'b0);
        chk1 ("rst.t2.ifStall", bus.ifStall, 1'b0);
        chk1 ("rst.t2.dmStall", bus.dmStall, 1'b0);
        @(negedge clk);
        bus.memReady = 1'b0;
        #1;
        chk1 ("rst.t3.dmDone", bus.dmDone, 1'b0);
        chk1 ("rst.t3.ifDone", bus.ifDone, 1'b0);
        chk1 ("rst.t3.memReq", bus.memReq, 1'b0);
        chk32("rst.t3.dmRdata", bus.dmRdata, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the instruction-fetch requester (IF) and the data-memory requester (MEM stage).
Serialises at most one outstanding memory transaction at a time, with fixed priority to MEM (the older instruction).
Returns read data through registered buffers and drives stall outputs so the pipeline holds IF/ID or EX/MEM until its access completes.
Honours the branch flush from ID by discarding an in-flight fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
ifReq  in  1  fetch request, held until ifDone
ifAddr  in  ADDR_W  fetch address (PC)
ifFlush  in  1  branch/jump flush from ID; discards the in-flight fetch
ifRdata  out  DATA_W  fetched instruction (registered)
ifDone  out  1  one-cycle pulse: ifRdata valid
ifStall  out  1  ifReq & ~ifDone (combinational)
dmReq  in  1  data request, held until dmDone
dmWe  in  1  1 = store, 0 = load
dmAddr  in  ADDR_W  data address
dmWdata  in  DATA_W  store data
dmRdata  out  DATA_W  load data (registered)
dmDone  out  1  one-cycle pulse: access complete
dmStall  out  1  dmReq & ~dmDone (combinational)
memReq  out  1  memory request, registered
memWe  out  1  memory write enable, registered
memAddr  out  ADDR_W  registered
memWdata  out  DATA_W  registered
memRdata  in  DATA_W  valid when memReady=1
memReady  in  1  completion from memory, sampled only while memReq=1

Behaviour:
- States: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE:
  - dmReq=1: latch dmAddr/dmWe/dmWdata into mem* regs; set memReq; go to BUSY_MEM.
  - Else ifReq=1: latch ifAddr, memWe=0; set memReq; go to BUSY_IF, clear discard flag.
  - dmReq has priority when both requests are high in the same cycle.
- BUSY_x:
  - memReq and latched fields are held stable until memReady=1.
  - On memReady: clear memReq.
    - BUSY_MEM: load captures memRdata into dmRdata; store leaves dmRdata unchanged. Go to DONE, target MEM.
    - BUSY_IF: if the discard flag is clear, capture ifRdata and go to DONE, target IF. If set, go to IDLE with no pulse and ifRdata unchanged.
- ifFlush=1 in any cycle while in BUSY_IF sets the discard flag, including the cycle memReady arrives. ifFlush has no effect in other states.
- DONE: pulse the target's Done for exactly one cycle, then go to IDLE. No new grant is made in DONE, because the requester's req is still high for the completed item.
- Latency: req seen at cycle t → memReq high t+1. memReady at t+1+k (k≥0) → Done high t+2+k. Earliest next grant decision at t+3+k.
- Done outputs are registered; the stall outputs are the only combinational outputs.
- Reset:
  - Clears state to IDLE; memReq, memWe, ifDone, dmDone and the discard flag go to 0.
  - memAddr, memWdata, ifRdata and dmRdata go to 0.
  - Reset mid-transaction abandons the access; the memory drops any access whose memReq falls before memReady.
- memReady while memReq=0 is ignored.
- Address/data are passed through unmodified; there is no alignment checking.

Test Plan:
- Fetch, zero-wait: ifReq=1, ifAddr=0x40, memReady at first memReq cycle with memRdata=0x8C220004 → memAddr=0x40 at t+1; ifDone pulse at t+2, ifRdata=0x8C220004; ifStall high t..t+1.
- Contention: ifReq and dmReq (load 0x100) both rise at t, memory latency 2 → MEM served first with dmDone at t+4. IF is granted at t+5 and ifDone arrives at t+8; ifStall stays high throughout.
- Store: dmWe=1, dmAddr=0x200, dmWdata=0xDEADBEEF → memWe=1, memWdata=0xDEADBEEF held until memReady; dmDone pulses; dmRdata keeps its prior value.
- Flush: ifFlush=1 in the second BUSY_IF cycle, memReady one cycle later → no ifDone, ifRdata unchanged, state IDLE. A new ifReq to 0x80 is then granted normally.
- Reset mid-access: rst=1 during BUSY_MEM with memReady low → next cycle memReq=0, state IDLE, all outputs 0. memReady=1 after reset produces no Done.
- Back-to-back loads 0x10, 0x14 with zero-wait memory → dmDone at t+2 and t+5; no duplicate grant during DONE.
